// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and received-word bus for uart_rx
//
// Signals:
//   RX_IN          serial line, idle high                 (master -> slave)
//   Prescale       oversampling ratio 8/16/32             (master -> slave)
//   parity_enable  frame carries a parity bit             (master -> slave)
//   parity_type    0 = even, 1 = odd                      (master -> slave)
//   P_DATA         last good received word                (slave -> master)
//   Data_Valid     one-cycle pulse, P_DATA updated        (slave -> master)
//   parity_error   one-cycle pulse, parity mismatch       (slave -> master)
//   stop_error     one-cycle pulse, stop bit sampled 0    (slave -> master)
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  parity_error;
    logic                  stop_error;

    modport master (
        output RX_IN, Prescale, parity_enable, parity_type,
        input  P_DATA, Data_Valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, Prescale, parity_enable, parity_type,
        output P_DATA, Data_Valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority-vote sampling and parity/stop checks
//
// Ports:
//   CLK   oversampling clock (Prescale x baud)
//   RST   synchronous, active-high reset
//   bus   uart_rx_if.slave: RX_IN/Prescale/parity_enable/parity_type in,
//         P_DATA/Data_Valid/parity_error/stop_error out
// Optional macro RX_SYNC_EN: RX_IN passes through a 2-flop synchronizer
// (reset value 1) first, adding 2 cycles to every latency.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, next_state;

    logic rx;
`ifdef RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge CLK) begin
        if (RST) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], bus.RX_IN};
    end
    assign rx = rx_sync[1];
`else
    assign rx = bus.RX_IN;
`endif

    // Frame configuration is frozen when the start bit is first seen.
    logic [5:0]            p_lat;
    logic                  pe_lat;
    logic                  pt_lat;
    logic [5:0]            edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [1:0]            samp;
    logic                  bit_val;   // majority value of the current/last bit
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_err;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  dv_r, pe_r, se_r;

    logic [5:0] half;
    logic       last_edge, decide, maj;

    assign half      = {1'b0, p_lat[5:1]};
    assign last_edge = (edge_cnt == p_lat - 6'd1);
    assign decide    = (edge_cnt == half + 6'd1);
    // Third sample is the live line value at the deciding edge.
    assign maj       = (samp[0] & samp[1]) | (samp[0] & rx) | (samp[1] & rx);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!rx) next_state = START;
            START:  if (last_edge) next_state = bit_val ? IDLE : DATA;
            DATA:   if (last_edge && bit_cnt == LAST_BIT)
                        next_state = pe_lat ? PARITY : STOP;
            PARITY: if (last_edge) next_state = STOP;
            STOP:   if (last_edge) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_lat     <= '0;
            pe_lat    <= 1'b0;
            pt_lat    <= 1'b0;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            samp      <= '0;
            bit_val   <= 1'b0;
            shift_reg <= '0;
            par_err   <= 1'b0;
            p_data_r  <= '0;
            dv_r      <= 1'b0;
            pe_r      <= 1'b0;
            se_r      <= 1'b0;
        end else begin
            dv_r <= 1'b0;
            pe_r <= 1'b0;
            se_r <= 1'b0;
            if (state == IDLE) begin
                // The first low cycle is edge 0, so the next cycle is edge 1.
                if (!rx) begin
                    p_lat    <= bus.Prescale;
                    pe_lat   <= bus.parity_enable;
                    pt_lat   <= bus.parity_type;
                    edge_cnt <= 6'd1;
                    bit_cnt  <= '0;
                    par_err  <= 1'b0;
                end else begin
                    edge_cnt <= '0;
                end
            end else begin
                edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) samp[0] <= rx;
                if (edge_cnt == half)        samp[1] <= rx;
                if (decide) begin
                    bit_val <= maj;
                    if (state == DATA)
                        shift_reg[bit_cnt] <= maj;
                    if (state == PARITY)
                        par_err <= (maj != ((^shift_reg) ^ pt_lat));
                end
                if (last_edge && state == DATA)
                    bit_cnt <= bit_cnt + BIT_W'(1);
                // Exactly one outcome pulse per completed frame; parity wins over stop.
                if (last_edge && state == STOP) begin
                    if (par_err)       pe_r <= 1'b1;
                    else if (!bit_val) se_r <= 1'b1;
                    else begin
                        dv_r     <= 1'b1;
                        p_data_r <= shift_reg;
                    end
                end
            end
        end
    end

    assign bus.P_DATA       = p_data_r;
    assign bus.Data_Valid   = dv_r;
    assign bus.parity_error = pe_r;
    assign bus.stop_error   = se_r;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive stage; the downstream counterpart of the UART transmitter. It consumes the serial line and produces parallel words.
- Oversamples RX_IN at Prescale× the baud rate, detects the start bit, majority-samples each bit, and checks parity and stop bit.
- Emits a one-cycle Data_Valid with P_DATA for each good frame. Emits an error pulse instead when parity or stop fails.
- Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit(1).

Parameters:
DATA_WIDTH  8  number of data bits per frame

Ports:
CLK            input   1           oversampling clock (Prescale × baud)
RST            input   1           reset; synchronous, active-high
RX_IN          input   1           serial line, idle high
Prescale       input   6           oversampling ratio; legal values 8, 16, 32
parity_enable  input   1           1 = frame carries a parity bit
parity_type    input   1           0 = even, 1 = odd
P_DATA         output  DATA_WIDTH  last good received word
Data_Valid     output  1           one-cycle pulse: P_DATA updated with a good frame
parity_error   output  1           one-cycle pulse: parity mismatch, frame dropped
stop_error     output  1           one-cycle pulse: stop bit sampled 0, frame dropped

Behaviour:
- Reset: all outputs 0, P_DATA = 0, FSM goes to IDLE, all counters 0. Reset asserted mid-frame abandons the frame with no pulse.
- Clock: one clock sets the reference; synchronous active-high reset on RST.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- edge_cnt: counts 0..P-1 within a bit. bit_cnt indexes data bits. P is Prescale latched when leaving IDLE; Prescale changes mid-frame are ignored. Illegal Prescale values give undefined results.
- IDLE: the cycle RX_IN is seen 0 is edge 0 of the start bit; FSM goes to START.
- Sampling: RX_IN captured at edges P/2-1, P/2, P/2+1. Bit value = majority of the 3 samples, decided at edge P/2+1.
- START: if the start-bit value is 1 (glitch), return to IDLE at edge P-1 with no pulses. Otherwise go to DATA at edge P-1.
- DATA: shift the sampled bit into bit position bit_cnt (LSB first). After bit DATA_WIDTH-1, at edge P-1, go to PARITY if parity_enable, else STOP. parity_enable is latched with Prescale.
- PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. parity_type is latched with Prescale. A mismatch sets an internal error flag. Go to STOP at edge P-1.
- STOP: at edge P-1 go to IDLE. In the next cycle exactly one of these pulses for one cycle:
  - parity flag set → parity_error (parity has priority; stop_error is not also raised)
  - else stop bit 0 → stop_error
  - else Data_Valid, with P_DATA loaded in that same cycle
- P_DATA holds its value except on a Data_Valid cycle.
- Latency: Data_Valid rises (DATA_WIDTH+2+parity_enable)·P cycles after the first cycle RX_IN is seen low. Example: 80 cycles for P=8, 8 bits, no parity.
- Back-to-back frames: the pulse cycle is also an IDLE cycle. If RX_IN = 0 there, it is edge 0 of the next start bit; no dead cycle.
- Break condition (line held 0): stop_error, then a new frame starts immediately. It repeats until the line returns high.
- Maximum start-to-sample skew tolerated: ±(P/2-2) cycles.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before all logic. Every latency above grows by exactly 2 cycles.
- Undefined: RX_IN is used directly; the source must be synchronous to CLK.

Test Plan:
- Prescale=8, parity off, frame 0xA5 → Data_Valid pulse 80 cycles after start edge, P_DATA=0xA5, both errors stay 0.
- Prescale=16, parity_enable=1, even, 0x3C with parity bit 0 → Data_Valid at cycle 176, P_DATA=0x3C. Repeat with parity bit 1 → parity_error pulse only, P_DATA stays 0x3C.
- Prescale=8, RX_IN low for 3 cycles then high → no pulses, FSM back in IDLE by cycle 8. A following valid 0x5A is received correctly.
- Prescale=32, odd parity, 0xFF, correct parity, stop bit driven 0 → stop_error pulse only; Data_Valid stays 0.
- RST asserted during data bit 4 of a frame → outputs 0 on the next cycle. A subsequent 0x81 frame decodes correctly.
- Prescale=8, three back-to-back frames 0x01, 0x80, 0xC3 with no idle gap → three Data_Valid pulses exactly 80 cycles apart with matching P_DATA. Repeat with RX_SYNC_EN defined → same data, pulses shifted by +2 cycles.
